logic_unit_seq: RTL and testbench



---
 rtl/logic_unit_seq_if.sv | 26 ++
 rtl/logic_unit_seq.sv | 140 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_seq_if.sv
// Purpose : request/result bundle for logic_unit_seq.
// Signals : start/op/in1/in2 run from the requester to the unit.
//           busy/done/out/zero run from the unit back to the requester.
// Modports: master = requester (control unit or bench), slave = logic unit.
interface logic_unit_seq_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             zero;

   modport master (
      output start, op, in1, in2,
      input  busy, done, out, zero
   );

   modport slave (
      input  start, op, in1, in2,
      output busy, done, out, zero
   );
endinterface

// File: rtl/logic_unit_seq.sv
// Purpose : multi-cycle bitwise logic unit. It applies AND/OR/XOR/NOR to two
//           WIDTH-bit operands, LANE bits per clock, over WIDTH/LANE cycles.
//           A start/busy/done handshake reports progress, and a zero flag
//           describes the last completed result.
// Ports   : clock - system clock, rising edge
//           reset - asynchronous, active-high
//           bus   - logic_unit_seq_if.slave (start, op, in1, in2 -> busy, done, out, zero)
// Opcodes : 00 AND, 01 OR, 10 XOR, 11 NOR
module logic_unit_seq #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LANE  = 1
) (
   input logic             clock,
   input logic             reset,
   logic_unit_seq_if.slave bus
);
   localparam int unsigned N    = WIDTH / LANE;
   localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             w_accept;
   logic             w_step;
   logic             w_last;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_out_next;
   logic             r_busy;
   logic             r_done;
   logic             r_zero;

   // Full-width function of the captured operands. The operation is purely
   // bitwise, so lane i of this word is exactly the lane-i result.
   always_comb begin
      w_res = '0;
      case (r_op)
         2'b00:   w_res = r_a & r_b;
         2'b01:   w_res = r_a | r_b;
         2'b10:   w_res = r_a ^ r_b;
         default: w_res = ~(r_a | r_b);
      endcase
   end

   // Merge only the lane selected by the counter into the result register.
   always_comb begin
      w_out_next = r_out;
      for (int unsigned i = 0; i < N; i++) begin
         if (CW'(i) == r_cnt) begin
            w_out_next[i*LANE +: LANE] = w_res[i*LANE +: LANE];
         end
      end
   end

   // Next-state decode. start is honoured only in IDLE or DONE.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      w_last       = (r_cnt == LAST);
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = S_RUN;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath and registered handshake outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_op   <= '0;
         r_cnt  <= '0;
         r_out  <= '0;
         r_zero <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_next_state == S_RUN);
         r_done <= (w_next_state == S_DONE);
         if (w_accept) begin
            r_a   <= bus.in1;
            r_b   <= bus.in2;
            r_op  <= bus.op;
            r_cnt <= '0;
            r_out <= '0;
         end else if (w_step) begin
            r_out <= w_out_next;
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            // zero covers the final lane being written this cycle
            if (w_last) begin
               r_zero <= (w_out_next == '0);
            end
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.out  = r_out;
   assign bus.zero = r_zero;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Purpose : self-checking bench for logic_unit_seq in three shapes:
//           A = WIDTH 4 / LANE 1, B = WIDTH 8 / LANE 4, C = WIDTH 8 / LANE 8.
//           Expected results are queued at issue time and compared on done.
module tb_logic_unit_seq;
   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   logic_unit_seq_if #(.WIDTH(4)) if_a ();
   logic_unit_seq_if #(.WIDTH(8)) if_b ();
   logic_unit_seq_if #(.WIDTH(8)) if_c ();

   logic_unit_seq #(.WIDTH(4), .LANE(1)) u_a (.clock(clock), .reset(reset), .bus(if_a));
   logic_unit_seq #(.WIDTH(8), .LANE(4)) u_b (.clock(clock), .reset(reset), .bus(if_b));
   logic_unit_seq #(.WIDTH(8), .LANE(8)) u_c (.clock(clock), .reset(reset), .bus(if_c));

   typedef struct {
      logic [7:0] out;
      logic       zero;
   } exp_t;

   typedef struct {
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] exp_out;
      logic       exp_zero;
   } vec4_t;

   typedef struct {
      bit         sel_c;
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_out;
      logic       exp_zero;
   } vec8_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];
   exp_t e_a, e_b, e_c;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: every done pulse must match the oldest expectation.
   always @(negedge clock) begin
      if (!reset && if_a.done) begin
         if (q_a.size() == 0) chk("a_unexpected_done", 32'(if_a.done), 32'd0);
         else begin
            e_a = q_a.pop_front();
            chk("a_out", 32'(if_a.out), 32'(e_a.out[3:0]));
            chk("a_zero", 32'(if_a.zero), 32'(e_a.zero));
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && if_b.done) begin
         if (q_b.size() == 0) chk("b_unexpected_done", 32'(if_b.done), 32'd0);
         else begin
            e_b = q_b.pop_front();
            chk("b_out", 32'(if_b.out), 32'(e_b.out));
            chk("b_zero", 32'(if_b.zero), 32'(e_b.zero));
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && if_c.done) begin
         if (q_c.size() == 0) chk("c_unexpected_done", 32'(if_c.done), 32'd0);
         else begin
            e_c = q_c.pop_front();
            chk("c_out", 32'(if_c.out), 32'(e_c.out));
            chk("c_zero", 32'(if_c.zero), 32'(e_c.zero));
         end
      end
   end

   // Issue one op on A from a negedge; returns at the negedge showing done.
   // Inputs are scrambled right after acceptance to prove they were captured.
   task automatic run_a(input vec4_t v, input string tag);
      int busy_n;
      int done_at;
      if_a.start = 1'b1;
      if_a.op    = v.op;
      if_a.in1   = v.a;
      if_a.in2   = v.b;
      q_a.push_back('{out: 8'(v.exp_out), zero: v.exp_zero});
      @(negedge clock);
      if_a.start = 1'b0;
      if_a.in1   = 4'hF;
      if_a.in2   = 4'hF;
      if_a.op    = ~v.op;
      busy_n  = 0;
      done_at = 0;
      for (int k = 1; k <= 12 && done_at == 0; k++) begin
         if (k > 1) @(negedge clock);
         if (if_a.busy) busy_n++;
         if (if_a.done) done_at = k;
      end
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
      chk({tag, "_done_latency"}, 32'(done_at), 32'd5);
   endtask

   // Same for the 8-bit units; B takes 2 RUN cycles, C takes 1.
   task automatic run8(input vec8_t v, input string tag);
      int busy_n;
      int done_at;
      int exp_busy;
      exp_busy = v.sel_c ? 1 : 2;
      if (v.sel_c) begin
         if_c.start = 1'b1; if_c.op = v.op; if_c.in1 = v.a; if_c.in2 = v.b;
         q_c.push_back('{out: v.exp_out, zero: v.exp_zero});
      end else begin
         if_b.start = 1'b1; if_b.op = v.op; if_b.in1 = v.a; if_b.in2 = v.b;
         q_b.push_back('{out: v.exp_out, zero: v.exp_zero});
      end
      @(negedge clock);
      if (v.sel_c) begin
         if_c.start = 1'b0; if_c.in1 = 8'hFF; if_c.in2 = 8'hFF; if_c.op = ~v.op;
      end else begin
         if_b.start = 1'b0; if_b.in1 = 8'hFF; if_b.in2 = 8'hFF; if_b.op = ~v.op;
      end
      busy_n  = 0;
      done_at = 0;
      for (int k = 1; k <= 12 && done_at == 0; k++) begin
         if (k > 1) @(negedge clock);
         if (v.sel_c ? if_c.busy : if_b.busy) busy_n++;
         if (v.sel_c ? if_c.done : if_b.done) done_at = k;
      end
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      chk({tag, "_done_latency"}, 32'(done_at), 32'(exp_busy + 1));
   endtask

   vec4_t va[8];
   vec8_t vb[6];

   initial begin
      int done_n;
      int done_at;

      va[0] = '{2'b00, 4'b1100, 4'b1010, 4'b1000, 1'b0};
      va[1] = '{2'b11, 4'b1111, 4'b0000, 4'b0000, 1'b1};
      va[2] = '{2'b10, 4'b0101, 4'b0011, 4'b0110, 1'b0};
      va[3] = '{2'b01, 4'b0000, 4'b0000, 4'b0000, 1'b1};
      va[4] = '{2'b01, 4'b1001, 4'b0100, 4'b1101, 1'b0};
      va[5] = '{2'b11, 4'b1010, 4'b0100, 4'b0001, 1'b0};
      va[6] = '{2'b00, 4'b1111, 4'b0111, 4'b0111, 1'b0};
      va[7] = '{2'b10, 4'b1111, 4'b1111, 4'b0000, 1'b1};

      vb[0] = '{1'b0, 2'b01, 8'hA0, 8'h05, 8'hA5, 1'b0};
      vb[1] = '{1'b0, 2'b11, 8'h0F, 8'h00, 8'hF0, 1'b0};
      vb[2] = '{1'b0, 2'b10, 8'h3C, 8'h3C, 8'h00, 1'b1};
      vb[3] = '{1'b1, 2'b00, 8'hF0, 8'h0F, 8'h00, 1'b1};
      vb[4] = '{1'b1, 2'b10, 8'hFF, 8'h0F, 8'hF0, 1'b0};
      vb[5] = '{1'b1, 2'b11, 8'h00, 8'h00, 8'hFF, 1'b0};

      reset = 1'b1;
      if_a.start = 1'b0; if_a.op = '0; if_a.in1 = '0; if_a.in2 = '0;
      if_b.start = 1'b0; if_b.op = '0; if_b.in1 = '0; if_b.in2 = '0;
      if_c.start = 1'b0; if_c.op = '0; if_c.in1 = '0; if_c.in2 = '0;
      repeat (2) @(negedge clock);

      chk("rst_busy", 32'(if_a.busy), 32'd0);
      chk("rst_done", 32'(if_a.done), 32'd0);
      chk("rst_out",  32'(if_a.out),  32'd0);
      chk("rst_zero", 32'(if_a.zero), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Table: first op from IDLE, the rest issued in each DONE cycle.
      for (int i = 0; i < 8; i++) run_a(va[i], $sformatf("a_vec%0d", i));
      @(negedge clock);
      chk("a_idle_busy", 32'(if_a.busy), 32'd0);
      chk("a_idle_done", 32'(if_a.done), 32'd0);
      chk("a_idle_zero_hold", 32'(if_a.zero), 32'd1);

      // start during RUN is ignored; one done pulse on the original schedule.
      if_a.start = 1'b1; if_a.op = 2'b01; if_a.in1 = 4'b0011; if_a.in2 = 4'b0100;
      q_a.push_back('{out: 8'h07, zero: 1'b0});
      done_n  = 0;
      done_at = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         if (k == 1) begin
            if_a.start = 1'b0;
            chk("a_out_cleared_on_start", 32'(if_a.out), 32'd0);
            chk("a_zero_held_in_run", 32'(if_a.zero), 32'd1);
         end
         if (k == 2) begin
            if_a.start = 1'b1; if_a.op = 2'b00; if_a.in1 = 4'b0000; if_a.in2 = 4'b0000;
         end
         if (k == 3) if_a.start = 1'b0;
         if (if_a.done) begin
            done_n++;
            if (done_at == 0) done_at = k;
         end
      end
      chk("a_ignore_done_count", 32'(done_n), 32'd1);
      chk("a_ignore_done_latency", 32'(done_at), 32'd5);
      chk("a_out_hold", 32'(if_a.out), 32'd7);
      chk("a_busy_after_ignore", 32'(if_a.busy), 32'd0);

      // Reset in the 3rd RUN cycle: abandon at once, no done afterwards.
      run_a('{2'b11, 4'b1111, 4'b1111, 4'b0000, 1'b1}, "a_pre_reset");
      if_a.start = 1'b1; if_a.op = 2'b01; if_a.in1 = 4'b1111; if_a.in2 = 4'b0000;
      @(negedge clock);
      if_a.start = 1'b0;
      repeat (2) @(negedge clock);
      chk("a_busy_before_reset", 32'(if_a.busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("a_reset_busy", 32'(if_a.busy), 32'd0);
      chk("a_reset_done", 32'(if_a.done), 32'd0);
      chk("a_reset_out",  32'(if_a.out),  32'd0);
      chk("a_reset_zero", 32'(if_a.zero), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      done_n = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (if_a.done || if_a.busy) done_n++;
      end
      chk("a_no_activity_after_reset", 32'(done_n), 32'd0);
      run_a('{2'b01, 4'b1010, 4'b0101, 4'b1111, 1'b0}, "a_post_reset");
      @(negedge clock);

      // 8-bit shapes, table-driven with back-to-back issue.
      for (int i = 0; i < 6; i++) run8(vb[i], $sformatf("%s_vec%0d", vb[i].sel_c ? "c" : "b", i));
      @(negedge clock);
      chk("b_idle_out_hold", 32'(if_b.out), 32'h00);
      chk("b_idle_zero_hold", 32'(if_b.zero), 32'd1);
      chk("c_idle_out_hold", 32'(if_c.out), 32'hFF);
      chk("c_idle_busy", 32'(if_c.busy), 32'd0);

      repeat (3) @(negedge clock);
      chk("a_queue_drained", 32'(q_a.size()), 32'd0);
      chk("b_queue_drained", 32'(q_b.size()), 32'd0);
      chk("c_queue_drained", 32'(q_c.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end
endmodule
